// File: rtl/piece_stamper_pkg.sv
// -----------------------------------------------------------------------------
// piece_stamper_pkg
//   Shared tetris definitions: default playfield size, the stamper FSM state
//   encoding and the 4x4 shape-matrix bit-index convention.
//   No ports (package).
// -----------------------------------------------------------------------------
package piece_stamper_pkg;

  localparam int unsigned BOARD_W_DEF = 10;
  localparam int unsigned BOARD_H_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WRITE,
    ST_FIN
  } stamp_state_e;

  // Cell index i = 4*row + col maps to matrix bit 15-i (MSB = row 0 / col 0).
  function automatic logic [3:0] cell_bit(input logic [3:0] idx);
    return 4'd15 - idx;
  endfunction

endpackage

// File: rtl/piece_stamper.sv
// -----------------------------------------------------------------------------
// piece_stamper
//   Walks the 16 cells of a latched 4x4 piece shape, one per cycle, and offers a
//   board-memory write (valid/ready) for every set cell that lands on the board.
//   Set cells off the board are skipped and raise a sticky out-of-bounds flag.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : one-cycle stamp request, sampled only when idle
//   block_matrix : 4x4 shape, bit 15-4r-c = row r / column c
//   pos_x, pos_y : board column / row of matrix cell (0,0)
//   wr_valid     : cell write offered
//   wr_ready     : board memory accepts the offered write
//   wr_x, wr_y   : board column / row of the offered write
//   busy         : stamp in progress
//   done         : one-cycle completion pulse
//   oob          : valid with done, some set cell fell off the board
//   cell_cnt     : valid with done, number of cells written (saturates at 7)
// -----------------------------------------------------------------------------
module piece_stamper
  import piece_stamper_pkg::*;
#(
  parameter int unsigned BOARD_W = BOARD_W_DEF,
  parameter int unsigned BOARD_H = BOARD_H_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] block_matrix,
  input  logic [3:0]  pos_x,
  input  logic [4:0]  pos_y,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [3:0]  wr_x,
  output logic [4:0]  wr_y,
  output logic        busy,
  output logic        done,
  output logic        oob,
  output logic [2:0]  cell_cnt
);

  localparam logic [4:0] LP_W = 5'(BOARD_W);
  localparam logic [5:0] LP_H = 6'(BOARD_H);

  stamp_state_e r_state;
  stamp_state_e w_next;

  logic [15:0] r_matrix;
  logic [3:0]  r_pos_x;
  logic [4:0]  r_pos_y;
  logic [3:0]  r_idx;
  logic        r_oob_sticky;
  logic [2:0]  r_cnt;
  logic [3:0]  r_wr_x;
  logic [4:0]  r_wr_y;
  logic        r_done;
  logic        r_oob;

  // Sums are one bit wider than the operands so an off-board cell can never
  // wrap around onto the board.
  logic [4:0]  w_sum_x;
  logic [5:0]  w_sum_y;
  logic        w_cell;
  logic        w_in_board;
  logic        w_last;
  logic        w_accept;

  assign w_sum_x    = {1'b0, r_pos_x} + {3'b000, r_idx[1:0]};
  assign w_sum_y    = {1'b0, r_pos_y} + {4'b0000, r_idx[3:2]};
  assign w_cell     = r_matrix[cell_bit(r_idx)];
  assign w_in_board = (w_sum_x < LP_W) && (w_sum_y < LP_H);
  assign w_last     = (r_idx == 4'd15);
  assign w_accept   = (r_state == ST_WRITE) && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_SCAN;
      ST_SCAN: begin
        if (w_cell && w_in_board) w_next = ST_WRITE;
        else if (w_last)          w_next = ST_FIN;
      end
      ST_WRITE: if (wr_ready) w_next = w_last ? ST_FIN : ST_SCAN;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_matrix     <= '0;
      r_pos_x      <= '0;
      r_pos_y      <= '0;
      r_idx        <= '0;
      r_oob_sticky <= 1'b0;
      r_cnt        <= '0;
      r_wr_x       <= '0;
      r_wr_y       <= '0;
      r_done       <= 1'b0;
      r_oob        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_oob  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_matrix     <= block_matrix;
            r_pos_x      <= pos_x;
            r_pos_y      <= pos_y;
            r_idx        <= '0;
            r_oob_sticky <= 1'b0;
            r_cnt        <= '0;
          end
        end
        ST_SCAN: begin
          if (w_cell && w_in_board) begin
            // Index holds here; it advances once the write is accepted.
            r_wr_x <= w_sum_x[3:0];
            r_wr_y <= w_sum_y[4:0];
          end else begin
            if (w_cell) r_oob_sticky <= 1'b1;
            r_idx <= r_idx + 4'd1;
          end
        end
        ST_WRITE: begin
          if (w_accept) begin
            if (r_cnt != 3'd7) r_cnt <= r_cnt + 3'd1;
            r_idx <= r_idx + 4'd1;
          end
        end
        ST_FIN: begin
          r_done <= 1'b1;
          r_oob  <= r_oob_sticky;
        end
        default: ;
      endcase
    end
  end

  assign wr_valid = (r_state == ST_WRITE);
  assign busy     = (r_state != ST_IDLE);
  assign wr_x     = r_wr_x;
  assign wr_y     = r_wr_y;
  assign done     = r_done;
  assign oob      = r_oob;
  assign cell_cnt = r_cnt;

endmodule

// File: tb/tb_piece_stamper.sv
// -----------------------------------------------------------------------------
// tb_piece_stamper
//   Directed bench for piece_stamper. A behavioural model predicts, from the
//   shape and position, the ordered list of on-board writes, the oob flag, the
//   cell count and the completion cycle; a single monitor compares every cycle.
// -----------------------------------------------------------------------------
module tb_piece_stamper;

  localparam int W = 10;
  localparam int H = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] block_matrix = '0;
  logic [3:0]  pos_x = '0;
  logic [4:0]  pos_y = '0;
  logic        wr_ready = 1'b0;
  logic        wr_valid;
  logic [3:0]  wr_x;
  logic [4:0]  wr_y;
  logic        busy;
  logic        done;
  logic        oob;
  logic [2:0]  cell_cnt;

  piece_stamper #(.BOARD_W(W), .BOARD_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .block_matrix(block_matrix),
    .pos_x(pos_x), .pos_y(pos_y), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .busy(busy), .done(done), .oob(oob),
    .cell_cnt(cell_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 0;   // 0: ready high, 1: 3 stall cycles per write, 2: ready low

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // wr_ready driver
  initial begin
    int stall = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: wr_ready = 1'b1;
        1: begin
          if (wr_valid) begin
            if (stall < 3) begin wr_ready = 1'b0; stall++; end
            else begin wr_ready = 1'b1; stall = 0; end
          end else begin
            wr_ready = 1'b1;  // ready while nothing is offered must be harmless
            stall = 0;
          end
        end
        default: wr_ready = 1'b0;
      endcase
    end
  end

  // ---------------- model + monitor ----------------
  bit m_busy = 0;
  bit m_oob;
  int m_cnt, t_neg, m_nacc, m_stalls;
  int q_x[$], q_y[$];
  int log_x[$], log_y[$];
  bit prev_stall = 0;
  int prev_x, prev_y;
  int done_cnt = 0;
  int cap_lat, cap_cnt, cap_oob;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_busy = 0;
      q_x.delete();
      q_y.delete();
      prev_stall = 0;
    end else begin
      bit exp_done;
      exp_done = m_busy && (cyc - t_neg == 18 + m_nacc + m_stalls);
      check("done", int'(done), int'(exp_done));
      check("busy", int'(busy), int'(m_busy && !exp_done));
      if (!exp_done) check("oob_idle", int'(oob), 0);
      if (done) begin
        cap_lat = cyc - t_neg;
        cap_cnt = int'(cell_cnt);
        cap_oob = int'(oob);
        done_cnt++;
      end
      if (exp_done) begin
        check("oob", int'(oob), int'(m_oob));
        check("cell_cnt", int'(cell_cnt), (m_cnt > 7) ? 7 : m_cnt);
        check("writes_left", q_x.size(), 0);
        m_busy = 0;
      end
      if (prev_stall) begin
        check("hold_valid", int'(wr_valid), 1);
        check("hold_x", int'(wr_x), prev_x);
        check("hold_y", int'(wr_y), prev_y);
      end
      if (wr_valid) begin
        if (q_x.size() == 0) check("spurious_write", int'(wr_valid), 0);
        else if (wr_ready) begin
          check("wr_x", int'(wr_x), q_x[0]);
          check("wr_y", int'(wr_y), q_y[0]);
          void'(q_x.pop_front());
          void'(q_y.pop_front());
          log_x.push_back(int'(wr_x));
          log_y.push_back(int'(wr_y));
          m_nacc++;
        end else m_stalls++;
      end
      prev_stall = wr_valid && !wr_ready;
      prev_x = int'(wr_x);
      prev_y = int'(wr_y);
      if (start && !m_busy) begin
        logic [15:0] mat;
        mat = block_matrix;
        m_busy = 1; m_oob = 0; m_cnt = 0;
        t_neg = cyc; m_nacc = 0; m_stalls = 0;
        q_x.delete(); q_y.delete(); log_x.delete(); log_y.delete();
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            if (mat[15 - 4*r - c]) begin
              if (int'(pos_x) + c < W && int'(pos_y) + r < H) begin
                q_x.push_back(int'(pos_x) + c);
                q_y.push_back(int'(pos_y) + r);
                m_cnt++;
              end else m_oob = 1;
            end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input logic [15:0] m, input int x, input int y);
    @(posedge clk);
    #1;
    start = 1'b1;
    block_matrix = m;
    pos_x = x[3:0];
    pos_y = y[4:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    block_matrix = ~m;      // latched copy must not follow these
    pos_x = ~pos_x;
    pos_y = ~pos_y;
  endtask

  task automatic run(input string name, input logic [15:0] m, input int x, input int y,
                     input int exp_lat, input int exp_cnt, input int exp_oob);
    int d0;
    int k;
    d0 = done_cnt;
    pulse_start(m, x, y);
    k = 0;
    while (done_cnt == d0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1;
    check({name, "_completed"}, done_cnt - d0, 1);
    check({name, "_lat"}, cap_lat, exp_lat);
    check({name, "_cnt"}, cap_cnt, exp_cnt);
    check({name, "_oob"}, cap_oob, exp_oob);
  endtask

  task automatic check_log(input string name, input int n, input int xs[4], input int ys[4]);
    check({name, "_nwrites"}, log_x.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < log_x.size()) begin
        check($sformatf("%s_w%0d_x", name, i), log_x[i], xs[i]);
        check($sformatf("%s_w%0d_y", name, i), log_y[i], ys[i]);
      end
    end
  endtask

  initial begin
    bit seen;
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(wr_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_oob", int'(oob), 0);
    check("rst_wr_x", int'(wr_x), 0);
    check("rst_wr_y", int'(wr_y), 0);
    check("rst_cnt", int'(cell_cnt), 0);
    rst_n = 1'b1;

    // Vertical bar in column 2 of the matrix
    ready_mode = 0;
    run("bar", 16'h2222, 3, 0, 22, 4, 0);
    check_log("bar", 4, '{5, 5, 5, 5}, '{0, 1, 2, 3});

    // Square clipped by the right edge
    run("square", 16'h0660, 8, 5, 20, 2, 1);
    check_log("square", 2, '{9, 9, 0, 0}, '{6, 7, 0, 0});

    // T piece with back-pressure on every write
    ready_mode = 1;
    run("tee", 16'h4C40, 0, 0, 34, 4, 0);
    check_log("tee", 4, '{1, 0, 1, 1}, '{0, 1, 1, 2});
    ready_mode = 0;

    // Empty shape
    run("empty", 16'h0000, 0, 0, 18, 0, 0);
    check_log("empty", 0, '{0, 0, 0, 0}, '{0, 0, 0, 0});

    // Bottom-right corner cells: (15,15) wraps neither axis
    run("corner", 16'h8001, 9, 19, 19, 1, 1);
    check_log("corner", 1, '{9, 0, 0, 0}, '{19, 0, 0, 0});

    // Start while busy is ignored
    fork
      run("busy_start", 16'h8001, 2, 3, 20, 2, 0);
      begin
        repeat (6) @(posedge clk);
        #2;
        start = 1'b1;
        block_matrix = 16'hFFFF;
        pos_x = 4'd0;
        pos_y = 5'd0;
        @(posedge clk);
        #2;
        start = 1'b0;
      end
    join
    check_log("busy_start", 2, '{2, 5, 0, 0}, '{3, 6, 0, 0});

    // Reset while a write is offered
    ready_mode = 2;
    pulse_start(16'h8000, 3, 4);
    k = 0;
    while (!wr_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("rstw_reach_write", int'(wr_valid), 1);
    check("rstw_wr_x_before", int'(wr_x), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_valid", int'(wr_valid), 0);
    check("rstw_busy", int'(busy), 0);
    check("rstw_wr_x", int'(wr_x), 0);
    check("rstw_wr_y", int'(wr_y), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("rstw_no_done", int'(seen), 0);
    run("after_rst", 16'h2222, 3, 0, 22, 4, 0);
    check_log("after_rst", 4, '{5, 5, 5, 5}, '{0, 1, 2, 3});

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
